// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider: each channel emits a registered divided
// clock and a one-cycle tick per period; divisor updates take effect at period boundaries.
module clk_div_gen #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned CW          = 8,
  parameter int unsigned DEFAULT_DIV = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCH-1:0]      en,
  input  logic                sync,
  input  logic [NCH-1:0]      div_load,
  input  logic [NCH*CW-1:0]   div_val,
  output logic [NCH-1:0]      clk_out,
  output logic [NCH-1:0]      tick
);

  localparam logic [CW-1:0] MIN_DIV = CW'(2);
  localparam logic [CW-1:0] RST_DIV = CW'(DEFAULT_DIV);

  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0][CW-1:0] cur_div_q, cur_div_d;
  logic [NCH-1:0][CW-1:0] pend_div_q, pend_div_d;
  logic [NCH-1:0]         pend_vld_q, pend_vld_d;
  logic [NCH-1:0]         clk_out_q, clk_out_d;
  logic [NCH-1:0]         tick_q, tick_d;

  logic [CW-1:0] ld_val;
  logic [CW-1:0] nxt_div;
  logic [CW-1:0] half;
  logic [CW-1:0] cnt_m1;
  logic          reload;

  // Per-channel next state; a load coinciding with a reload bypasses the shadow register.
  always_comb begin
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    clk_out_d  = clk_out_q;
    tick_d     = '0;
    ld_val     = '0;
    nxt_div    = '0;
    half       = '0;
    cnt_m1     = '0;
    reload     = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      ld_val  = div_val[i*CW +: CW];
      if (ld_val < MIN_DIV) ld_val = MIN_DIV;
      reload  = en[i] && ((cnt_q[i] == '0) || sync);
      nxt_div = div_load[i] ? ld_val : (pend_vld_q[i] ? pend_div_q[i] : cur_div_q[i]);
      half    = (cur_div_q[i] >> 1) + CW'(cur_div_q[i][0]);
      cnt_m1  = cnt_q[i] - CW'(1);

      if (div_load[i]) begin
        pend_div_d[i] = ld_val;
        pend_vld_d[i] = 1'b1;
      end

      if (reload) begin
        cur_div_d[i]  = nxt_div;
        cnt_d[i]      = nxt_div - CW'(1);
        pend_vld_d[i] = 1'b0;
        tick_d[i]     = 1'b1;
        clk_out_d[i]  = 1'b1;
      end else if (en[i]) begin
        cnt_d[i]     = cnt_m1;
        // High for the first ceil(div/2) cycles of the period.
        clk_out_d[i] = (cnt_m1 >= (cur_div_q[i] - half));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cur_div_q  <= {NCH{RST_DIV}};
      pend_div_q <= '0;
      pend_vld_q <= '0;
      clk_out_q  <= '0;
      tick_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Bench for clk_div_gen: directed scenarios plus random traffic against a
// period-position reference model.
module tb_clk_div_gen;

  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = 8;
  localparam int unsigned DEF = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    en;
  logic              sync;
  logic [NCH-1:0]    div_load;
  logic [NCH*CW-1:0] div_val;
  logic [NCH-1:0]    clk_out;
  logic [NCH-1:0]    tick;

  int total = 0;
  int bad   = 0;

  // Reference model: position within the current period and its length.
  int             m_pos  [NCH];
  int             m_div  [NCH];
  int             m_pend [NCH];
  bit             m_run  [NCH];
  logic [NCH-1:0] m_clk;
  logic [NCH-1:0] m_tick;

  clk_div_gen #(.NCH(NCH), .CW(CW), .DEFAULT_DIV(DEF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sync     (sync),
    .div_load (div_load),
    .div_val  (div_val),
    .clk_out  (clk_out),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NCH); i++) begin
      m_pos[i] = 0; m_div[i] = int'(DEF); m_pend[i] = 0; m_run[i] = 1'b0;
    end
    m_clk = '0; m_tick = '0;
  endtask

  task automatic model_edge();
    int v, d;
    for (int i = 0; i < int'(NCH); i++) begin
      v = clampv(int'(div_val[i*CW +: CW]));
      if (en[i]) begin
        if (!m_run[i] || m_pos[i] == m_div[i] - 1 || sync) begin
          d = div_load[i] ? v : ((m_pend[i] != 0) ? m_pend[i] : m_div[i]);
          m_div[i] = d; m_pend[i] = 0; m_pos[i] = 0; m_run[i] = 1'b1;
          m_tick[i] = 1'b1; m_clk[i] = 1'b1;
        end else begin
          m_pos[i]++;
          m_tick[i] = 1'b0;
          m_clk[i]  = (m_pos[i] < (m_div[i] + 1) / 2);
          if (div_load[i]) m_pend[i] = v;
        end
      end else begin
        m_tick[i] = 1'b0;
        if (div_load[i]) m_pend[i] = v;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic set_div(input int ch, input int v);
    div_val[ch*CW +: CW] = CW'(v);
  endtask

  // Steps from a tick cycle to the next tick on channel ch, optionally loading
  // divisors on given edges. Returns period length (0 on timeout), clk_out bit
  // pattern and the number of cycles that disagreed with the model.
  task automatic run_period(input int ch, input int s0, input int v0, input int s1, input int v1,
                            output int len, output logic [31:0] pat, output int mm);
    len = 0; mm = 0; pat = '0;
    pat[0] = clk_out[ch];
    for (int s = 1; s <= 64; s++) begin
      div_load = '0;
      if (s == s0) begin div_load[ch] = 1'b1; set_div(ch, v0); end
      if (s == s1) begin div_load[ch] = 1'b1; set_div(ch, v1); end
      step();
      div_load = '0;
      if (clk_out !== m_clk || tick !== m_tick) mm++;
      if (tick[ch]) begin len = s; break; end
      if (s < 32) pat[s] = clk_out[ch];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = '0; sync = 1'b0; div_load = '0; div_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (clk_out !== 2'b00) begin bad++; $display("FAIL reset_clk_out: got %b want 00", clk_out); end
    total++; if (tick !== 2'b00) begin bad++; $display("FAIL reset_tick: got %b want 00", tick); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_default_run();
    en = 2'b01;
    for (int c = 1; c <= 15; c++) begin
      step();
      total++;
      if (tick[0] !== (((c - 1) % 5) == 0)) begin
        bad++; $display("FAIL default_tick c=%0d: got %b want %b", c, tick[0], ((c - 1) % 5) == 0);
      end
      total++;
      if (clk_out[0] !== (((c - 1) % 5) < 3)) begin
        bad++; $display("FAIL default_clk c=%0d: got %b want %b", c, clk_out[0], ((c - 1) % 5) < 3);
      end
      total++;
      if (clk_out[1] !== 1'b0 || tick[1] !== 1'b0) begin
        bad++; $display("FAIL default_ch1 c=%0d: got clk=%b tick=%b want 0 0", c, clk_out[1], tick[1]);
      end
    end
  endtask

  task automatic test_load_midperiod();
    int len, mm; logic [31:0] pat;
    step();
    total++; if (tick[0] !== 1'b1) begin bad++; $display("FAIL align_tick: got %b want 1", tick[0]); end
    run_period(0, 2, 4, -1, 0, len, pat, mm);
    total++; if (len !== 5 || pat !== 32'b00111 || mm !== 0) begin
      bad++; $display("FAIL load4_cur: got len=%0d pat=%b mm=%0d want len=5 pat=00111 mm=0", len, pat[7:0], mm); end
    run_period(0, -1, 0, -1, 0, len, pat, mm);
    total++; if (len !== 4 || pat !== 32'b0011 || mm !== 0) begin
      bad++; $display("FAIL load4_new: got len=%0d pat=%b mm=%0d want len=4 pat=0011 mm=0", len, pat[7:0], mm); end
    run_period(0, 1, 6, 2, 7, len, pat, mm);
    total++; if (len !== 4 || mm !== 0) begin
      bad++; $display("FAIL load67_cur: got len=%0d mm=%0d want len=4 mm=0", len, mm); end
    run_period(0, -1, 0, -1, 0, len, pat, mm);
    total++; if (len !== 7 || pat !== 32'b0001111 || mm !== 0) begin
      bad++; $display("FAIL load67_new: got len=%0d pat=%b mm=%0d want len=7 pat=0001111 mm=0", len, pat[7:0], mm); end
  endtask

  task automatic test_clamp_bypass();
    int len, mm; logic [31:0] pat;
    run_period(0, 1, 0, -1, 0, len, pat, mm);
    total++; if (len !== 7 || mm !== 0) begin bad++; $display("FAIL load0_cur: got len=%0d mm=%0d want 7 0", len, mm); end
    run_period(0, -1, 0, -1, 0, len, pat, mm);
    total++; if (len !== 2 || pat !== 32'b01 || mm !== 0) begin
      bad++; $display("FAIL clamp0: got len=%0d pat=%b mm=%0d want len=2 pat=01 mm=0", len, pat[7:0], mm); end
    run_period(0, 1, 1, -1, 0, len, pat, mm);
    total++; if (len !== 2 || mm !== 0) begin bad++; $display("FAIL load1_cur: got len=%0d mm=%0d want 2 0", len, mm); end
    run_period(0, 2, 3, -1, 0, len, pat, mm);
    total++; if (len !== 2 || pat !== 32'b01 || mm !== 0) begin
      bad++; $display("FAIL clamp1: got len=%0d pat=%b mm=%0d want len=2 pat=01 mm=0", len, pat[7:0], mm); end
    run_period(0, -1, 0, -1, 0, len, pat, mm);
    total++; if (len !== 3 || pat !== 32'b011 || mm !== 0) begin
      bad++; $display("FAIL bypass3: got len=%0d pat=%b mm=%0d want len=3 pat=011 mm=0", len, pat[7:0], mm); end
    run_period(0, -1, 0, -1, 0, len, pat, mm);
    total++; if (len !== 3 || mm !== 0) begin bad++; $display("FAIL bypass3_again: got len=%0d mm=%0d want 3 0", len, mm); end
  endtask

  task automatic test_enable_hold();
    int len, mm, n; logic [31:0] pat;
    run_period(0, 1, 5, -1, 0, len, pat, mm);
    run_period(0, -1, 0, -1, 0, len, pat, mm);
    total++; if (len !== 5 || mm !== 0) begin bad++; $display("FAIL hold_setup: got len=%0d mm=%0d want 5 0", len, mm); end
    repeat (2) step();
    en = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (clk_out[0] !== 1'b1 || tick[0] !== 1'b0) begin
        bad++; $display("FAIL hold_k%0d: got clk=%b tick=%b want 1 0", k, clk_out[0], tick[0]); end
    end
    en = 2'b01;
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (tick[0]) begin n = k; break; end
    end
    total++; if (2 + n !== 5) begin bad++; $display("FAIL hold_period: got %0d want 5", 2 + n); end
  endtask

  task automatic test_sync();
    int t0, t1;
    en = 2'b11; div_load = 2'b10; set_div(1, 3);
    step();
    div_load = '0;
    total++; if (tick !== m_tick || clk_out !== m_clk) begin
      bad++; $display("FAIL sync_start: got tick=%b clk=%b want tick=%b clk=%b", tick, clk_out, m_tick, m_clk); end
    for (int k = 0; k < 7; k++) begin
      step();
      total++; if (tick !== m_tick || clk_out !== m_clk) begin
        bad++; $display("FAIL sync_drift k=%0d: got tick=%b clk=%b want tick=%b clk=%b", k, tick, clk_out, m_tick, m_clk); end
    end
    sync = 1'b1; step(); sync = 1'b0;
    total++; if (tick !== 2'b11 || clk_out !== 2'b11) begin
      bad++; $display("FAIL sync_align: got tick=%b clk=%b want 11 11", tick, clk_out); end
    t0 = 0; t1 = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (tick[0] && t0 == 0) t0 = k;
      if (tick[1] && t1 == 0) t1 = k;
    end
    total++; if (t0 !== 5 || t1 !== 3) begin bad++; $display("FAIL sync_resume: got t0=%0d t1=%0d want 5 3", t0, t1); end
    en = 2'b01;
    repeat (2) step();
    sync = 1'b1; step(); sync = 1'b0;
    total++; if (tick !== 2'b01 || clk_out !== m_clk) begin
      bad++; $display("FAIL sync_masked: got tick=%b clk=%b want tick=01 clk=%b", tick, clk_out, m_clk); end
  endtask

  task automatic test_async_reset();
    int len, mm, n; logic [31:0] pat;
    n = 0;
    for (int k = 1; k <= 10; k++) begin step(); if (tick[0]) begin n = k; break; end end
    total++; if (n == 0) begin bad++; $display("FAIL rst_align: got no tick want tick within 10"); end
    div_load = 2'b01; set_div(0, 9); step(); div_load = '0;
    step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (clk_out !== 2'b00 || tick !== 2'b00) begin
      bad++; $display("FAIL async_rst: got clk=%b tick=%b want 00 00", clk_out, tick); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();
    total++; if (tick !== 2'b01 || clk_out !== 2'b01) begin
      bad++; $display("FAIL rst_first: got tick=%b clk=%b want 01 01", tick, clk_out); end
    run_period(0, -1, 0, -1, 0, len, pat, mm);
    total++; if (len !== 5 || pat !== 32'b00111 || mm !== 0) begin
      bad++; $display("FAIL rst_period: got len=%0d pat=%b mm=%0d want len=5 pat=00111 mm=0", len, pat[7:0], mm); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en = NCH'($urandom_range(0, 3));
      if ($urandom_range(0, 5) != 0) en = 2'b11;
      sync = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < int'(NCH); i++) begin
        div_load[i] = ($urandom_range(0, 7) == 0);
        set_div(i, int'($urandom_range(0, 9)));
      end
      step();
      sync = 1'b0; div_load = '0;
      total++; if (tick !== m_tick || clk_out !== m_clk) begin
        bad++; $display("FAIL random k=%0d: got tick=%b clk=%b want tick=%b clk=%b", k, tick, clk_out, m_tick, m_clk); end
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_load_midperiod();
    test_clamp_bypass();
    test_enable_hold();
    test_sync();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
